cart_header_parser: RTL
=======================

CART_HEADER_PARSER -- requirements
Module: cart_header_parser

Interface
REQ-001 SHALL have parameter DEFAULT_REGION, default 2'b01, region used when the header gives no region (encoding 00 JP, 01 US, 10 EU).
REQ-002 SHALL have port iclk  in  1  system clock; all state on rising edge.
REQ-003 SHALL have port ireset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port iloading  in  1  ROM download active (from ioctl_download).
REQ-005 SHALL have port iwr  in  1  write strobe; word valid this cycle (from ioctl_wr).
REQ-006 SHALL have port iaddr  in  27  byte address of word; even, steps of 2 (from ioctl_addr).
REQ-007 SHALL have port idata  in  16  ROM word; [15:8] = byte at iaddr, [7:0] = byte at iaddr+1.
REQ-008 SHALL have port ipriority  in  2  region priority: 00 US>EU>JP, 01 EU>US>JP, 10 US>JP>EU, 11 JP>US>EU.
REQ-009 SHALL have port oregion  out  2  resolved region, status[7:6] encoding.
REQ-010 SHALL have port oregion_valid  out  1  1 = region came from the header, 0 = DEFAULT_REGION used.
REQ-011 SHALL have port osega_ok  out  1  bytes 0x100..0x103 equal "SEGA" (53 45 47 41).
REQ-012 SHALL have port orom_size  out  25  highest written byte address + 2, saturating at 2^25-1.
REQ-013 SHALL have port odone  out  1  one-cycle pulse when the outputs update after a download.

Function
REQ-014 SHALL use FSM states IDLE, CAPTURE, DECODE, RESOLVE.
REQ-015 Any state, iloading rising (registered 0 -> 1): SHALL go to CAPTURE; clear capture registers to 0x00, the size counter to 0 and oregion_valid to 0. oregion and osega_ok SHALL hold.
REQ-016 In CAPTURE, cycles with iwr=1 and iloading=1: SHALL store idata for iaddr 0x100, 0x102 (SEGA), 0x1F0, 0x1F2 (region bytes 0x1F0..0x1F2; 0x1F3 ignored).
REQ-017 Same cycles: size counter SHALL become max(current, iaddr+2), saturating; iwr while not in CAPTURE SHALL be ignored.
REQ-018 CAPTURE with iloading sampled 0 at edge N: SHALL enter DECODE at N, RESOLVE at N+1; at N+2 update all outputs, assert odone for exactly that cycle, return to IDLE.
REQ-019 DECODE, old style: any of bytes 0x1F0..0x1F2 equal 'J'(4A), 'U'(55) or 'E'(45) SHALL set jp/us/eu flags; case-sensitive.
REQ-020 DECODE, new style (only when no letter matched): byte 0x1F0 is '0'-'9' or 'A'-'D','F' -> nibble value v; jp=v[0], us=v[2], eu=v[3]; v[1] ignored.
REQ-021 Any other content (including 0x00 bytes from a ROM shorter than 0x1F4) SHALL set no flags.
REQ-022 RESOLVE: ipriority SHALL be sampled in this cycle; oregion = highest-priority set flag, oregion_valid=1; no flag set -> oregion=DEFAULT_REGION, oregion_valid=0.
REQ-023 osega_ok and orom_size SHALL update on the same edge as oregion.
REQ-024 ipriority changes outside RESOLVE SHALL NOT affect outputs.
REQ-025 An iloading pulse with no writes SHALL still complete: outputs DEFAULT_REGION, valid 0, osega_ok 0, orom_size 0, odone pulse.

Reset
REQ-026 ireset=1 SHALL immediately force: state IDLE, capture registers 0x00, size counter 0, oregion=DEFAULT_REGION, oregion_valid=0, osega_ok=0, orom_size=0, odone=0, registered iloading=0.
REQ-027 ireset during CAPTURE/DECODE/RESOLVE SHALL abort with no odone pulse; the first iloading rise after release SHALL start a new capture.

Verification
REQ-028 Header "SEGA" at 0x100, "JUE" at 0x1F0, ipriority=00, 0x200000-byte ROM -> oregion=01, valid=1, osega_ok=1, orom_size=0x200000, odone one cycle at N+2.
REQ-029 Region byte "4" (0x34) + space, ipriority=01 -> us only -> oregion=01; byte "C" -> us+eu -> oregion=10; byte "1", ipriority=11 -> oregion=00.
REQ-030 Byte "E" + spaces -> eu only (old style wins), oregion=10; 256-byte ROM -> no flags, oregion=DEFAULT_REGION, valid=0, orom_size=0x100.
REQ-031 ireset pulse mid-CAPTURE, then a new download with "J  " -> no odone for the aborted load; second load gives oregion=00, valid=1.
REQ-032 iloading re-raised during DECODE -> returns to CAPTURE, no odone; oregion_valid=0 until the next completion.
REQ-033 ipriority toggled every cycle except RESOLVE (held 10), flags us+jp -> oregion=01.

Source files
------------

// File: rtl/cart_header_parser.sv
// Captures the cartridge header while a ROM downloads, then decodes the region
// letters or nibble, resolves them against a priority order and reports ROM size.
module cart_header_parser #(
  parameter logic [1:0] DEFAULT_REGION = 2'b01
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        iloading,
  input  logic        iwr,
  input  logic [26:0] iaddr,
  input  logic [15:0] idata,
  input  logic [1:0]  ipriority,
  output logic [1:0]  oregion,
  output logic        oregion_valid,
  output logic        osega_ok,
  output logic [24:0] orom_size,
  output logic        odone
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DECODE, RESOLVE} state_t;

  state_t      state_q, state_d;
  logic        loading_q, loading_d;
  logic [15:0] sega0_q, sega0_d, sega1_q, sega1_d, region0_q, region0_d;
  logic [7:0]  region2_q, region2_d;
  logic [24:0] size_q, size_d;
  logic [2:0]  flags_q, flags_d;
  logic [1:0]  region_q, region_d;
  logic        valid_q, valid_d, sega_ok_q, sega_ok_d, done_q, done_d;
  logic [24:0] rom_size_q, rom_size_d;

  logic [27:0] end_addr;
  logic [24:0] end_sat;
  logic [7:0]  b0, b1, b2;
  logic        let_jp, let_us, let_eu, nib_ok;
  logic [3:0]  nib;
  logic [2:0]  flags_dec;
  logic [1:0]  res_region;
  logic        res_valid;

  assign end_addr = {1'b0, iaddr} + 28'd2;
  assign end_sat  = (end_addr > 28'h1FFFFFF) ? 25'h1FFFFFF : end_addr[24:0];

  // Flags are packed {eu, us, jp}; letters anywhere in 0x1F0..0x1F2 win over the nibble form.
  always_comb begin
    b0 = region0_q[15:8];
    b1 = region0_q[7:0];
    b2 = region2_q;
    let_jp = (b0 == 8'h4A) || (b1 == 8'h4A) || (b2 == 8'h4A);
    let_us = (b0 == 8'h55) || (b1 == 8'h55) || (b2 == 8'h55);
    let_eu = (b0 == 8'h45) || (b1 == 8'h45) || (b2 == 8'h45);
    nib_ok = 1'b0;
    nib    = 4'h0;
    if (b0 >= 8'h30 && b0 <= 8'h39) begin
      nib_ok = 1'b1;
      nib    = b0[3:0];
    end else if (b0 >= 8'h41 && b0 <= 8'h44) begin
      nib_ok = 1'b1;
      nib    = b0[3:0] + 4'd9;
    end else if (b0 == 8'h46) begin
      nib_ok = 1'b1;
      nib    = 4'hF;
    end
    if (let_jp || let_us || let_eu) flags_dec = {let_eu, let_us, let_jp};
    else if (nib_ok)                flags_dec = {nib[3], nib[2], nib[0]};
    else                            flags_dec = 3'b000;
  end

  always_comb begin
    res_valid  = |flags_q;
    res_region = DEFAULT_REGION;
    case (ipriority)
      2'b00: begin
        if (flags_q[1])      res_region = 2'b01;
        else if (flags_q[2]) res_region = 2'b10;
        else if (flags_q[0]) res_region = 2'b00;
      end
      2'b01: begin
        if (flags_q[2])      res_region = 2'b10;
        else if (flags_q[1]) res_region = 2'b01;
        else if (flags_q[0]) res_region = 2'b00;
      end
      2'b10: begin
        if (flags_q[1])      res_region = 2'b01;
        else if (flags_q[0]) res_region = 2'b00;
        else if (flags_q[2]) res_region = 2'b10;
      end
      default: begin
        if (flags_q[0])      res_region = 2'b00;
        else if (flags_q[1]) res_region = 2'b01;
        else if (flags_q[2]) res_region = 2'b10;
      end
    endcase
  end

  // A fresh download rise restarts capture from any state, aborting any pending decode.
  always_comb begin
    state_d    = state_q;
    loading_d  = iloading;
    sega0_d    = sega0_q;
    sega1_d    = sega1_q;
    region0_d  = region0_q;
    region2_d  = region2_q;
    size_d     = size_q;
    flags_d    = flags_q;
    region_d   = region_q;
    valid_d    = valid_q;
    sega_ok_d  = sega_ok_q;
    rom_size_d = rom_size_q;
    done_d     = 1'b0;
    if (iloading && !loading_q) begin
      state_d   = CAPTURE;
      sega0_d   = 16'h0000;
      sega1_d   = 16'h0000;
      region0_d = 16'h0000;
      region2_d = 8'h00;
      size_d    = 25'd0;
      flags_d   = 3'b000;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (!iloading) begin
            state_d = DECODE;
          end else if (iwr) begin
            case (iaddr)
              27'h100: sega0_d   = idata;
              27'h102: sega1_d   = idata;
              27'h1F0: region0_d = idata;
              27'h1F2: region2_d = idata[15:8];
              default: ;
            endcase
            if (end_sat > size_q) size_d = end_sat;
          end
        end
        DECODE: begin
          flags_d = flags_dec;
          state_d = RESOLVE;
        end
        RESOLVE: begin
          region_d   = res_region;
          valid_d    = res_valid;
          sega_ok_d  = (sega0_q == 16'h5345) && (sega1_q == 16'h4741);
          rom_size_d = size_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q    <= IDLE;
      loading_q  <= 1'b0;
      sega0_q    <= 16'h0000;
      sega1_q    <= 16'h0000;
      region0_q  <= 16'h0000;
      region2_q  <= 8'h00;
      size_q     <= 25'd0;
      flags_q    <= 3'b000;
      region_q   <= DEFAULT_REGION;
      valid_q    <= 1'b0;
      sega_ok_q  <= 1'b0;
      rom_size_q <= 25'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      loading_q  <= loading_d;
      sega0_q    <= sega0_d;
      sega1_q    <= sega1_d;
      region0_q  <= region0_d;
      region2_q  <= region2_d;
      size_q     <= size_d;
      flags_q    <= flags_d;
      region_q   <= region_d;
      valid_q    <= valid_d;
      sega_ok_q  <= sega_ok_d;
      rom_size_q <= rom_size_d;
      done_q     <= done_d;
    end
  end

  assign oregion       = region_q;
  assign oregion_valid = valid_q;
  assign osega_ok      = sega_ok_q;
  assign orom_size     = rom_size_q;
  assign odone         = done_q;

endmodule
